wvb_rd_sched: RTL and testbench

- Round-robin readout scheduler for P_N_CHAN per-channel waveform buffers and their header FIFOs.
- Arbitrates among channels with a pending header, pops one header, walks that channel's waveform RAM from start address to stop address inclusive with wrap, and streams samples to one downstream valid/ready port.
- Pulses a per-channel done so the channel can free buffer space.
- Sits between the per-channel wvb_wr_ctrl/buffer pairs and the readout/DAQ FIFO.

---
 rtl/wvb_rd_pkg.sv | 22 ++
 rtl/wvb_rd_sched_rr_arbiter.sv | 32 +++
 rtl/wvb_rd_sched.sv | 161 ++++++++++++++++
 tb/tb_wvb_rd_sched.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wvb_rd_pkg.sv
// wvb_rd_pkg: shared header field layout and scheduler state encoding.
`default_nettype none

package wvb_rd_pkg;

   localparam int STOP_ADDR_LSB = 0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_POP   = 2'd1,
      S_RADDR = 2'd2,
      S_DATA  = 2'd3
   } state_e;

   // start_addr sits directly above stop_addr in the header word
   function automatic int start_addr_lsb(input int adr_width);
      return STOP_ADDR_LSB + adr_width;
   endfunction

endpackage

`default_nettype wire

// File: rtl/wvb_rd_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching ptr+1, ptr+2, ... modulo P_N_CHAN.
`default_nettype none

module rr_arbiter #(
   parameter int P_N_CHAN = 4,
   parameter int P_PTR_W  = $clog2(P_N_CHAN)
) (
   input  logic [P_N_CHAN-1:0] req_i,
   input  logic [P_PTR_W-1:0]  ptr_i,
   output logic [P_PTR_W-1:0]  grant_o,
   output logic                any_o
);

   int unsigned w_idx;

   // Walk from the farthest offset down so the nearest requester after ptr wins.
   always_comb begin
      grant_o = ptr_i;
      w_idx   = 0;
      for (int i = P_N_CHAN; i >= 1; i--) begin
         w_idx = (int'(ptr_i) + i) % P_N_CHAN;
         if (req_i[w_idx]) begin
            grant_o = P_PTR_W'(w_idx);
         end
      end
   end

   assign any_o = |req_i;

endmodule

`default_nettype wire

// File: rtl/wvb_rd_sched.sv
// wvb_rd_sched: round-robin readout of per-channel waveform buffers into one valid/ready stream.
`default_nettype none

module wvb_rd_sched
   import wvb_rd_pkg::*;
#(
   parameter int P_N_CHAN     = 4,
   parameter int P_DATA_WIDTH = 22,
   parameter int P_ADR_WIDTH  = 12,
   parameter int P_HDR_WIDTH  = 160
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               en,
   input  logic [P_N_CHAN-1:0]                hdr_empty,
   input  logic [P_N_CHAN*P_HDR_WIDTH-1:0]    hdr_data,
   output logic [P_N_CHAN-1:0]                hdr_rdreq,
   output logic [P_ADR_WIDTH-1:0]             wvb_rd_addr,
   input  logic [P_N_CHAN*P_DATA_WIDTH-1:0]   wvb_rd_data,
   output logic                               dout_valid,
   input  logic                               dout_ready,
   output logic [P_DATA_WIDTH-1:0]            dout_data,
   output logic                               dout_sop,
   output logic                               dout_eop,
   output logic [P_HDR_WIDTH-1:0]             dout_hdr,
   output logic [$clog2(P_N_CHAN)-1:0]        dout_chan,
   output logic [P_N_CHAN-1:0]                rd_done,
   output logic                               busy
);

   localparam int CW             = $clog2(P_N_CHAN);
   localparam int START_ADDR_LSB = start_addr_lsb(P_ADR_WIDTH);

   state_e                  state_q, state_d;
   logic [CW-1:0]           ptr_q, ptr_d;
   logic [CW-1:0]           gnt_q, gnt_d;
   logic [P_HDR_WIDTH-1:0]  hdr_q, hdr_d;
   logic [P_ADR_WIDTH-1:0]  addr_q, addr_d;
   logic [P_ADR_WIDTH-1:0]  rem_q, rem_d;
   logic                    sop_q, sop_d;
   logic [P_DATA_WIDTH-1:0] data_q, data_d;
   logic                    first_q, first_d;

   logic [CW-1:0]           w_grant;
   logic                    w_any;
   logic [P_HDR_WIDTH-1:0]  w_hdr_sel;
   logic [P_DATA_WIDTH-1:0] w_rd_sel;
   logic [P_ADR_WIDTH-1:0]  w_start;
   logic [P_ADR_WIDTH-1:0]  w_stop;

   rr_arbiter #(
      .P_N_CHAN (P_N_CHAN),
      .P_PTR_W  (CW)
   ) u_arb (
      .req_i   (~hdr_empty),
      .ptr_i   (ptr_q),
      .grant_o (w_grant),
      .any_o   (w_any)
   );

   assign w_hdr_sel = hdr_data[gnt_q*P_HDR_WIDTH +: P_HDR_WIDTH];
   assign w_rd_sel  = wvb_rd_data[gnt_q*P_DATA_WIDTH +: P_DATA_WIDTH];
   assign w_start   = w_hdr_sel[START_ADDR_LSB +: P_ADR_WIDTH];
   assign w_stop    = w_hdr_sel[STOP_ADDR_LSB +: P_ADR_WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= CW'(P_N_CHAN - 1);
         gnt_q   <= '0;
         hdr_q   <= '0;
         addr_q  <= '0;
         rem_q   <= '0;
         sop_q   <= 1'b0;
         data_q  <= '0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         hdr_q   <= hdr_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         sop_q   <= sop_d;
         data_q  <= data_d;
         first_q <= first_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gnt_d      = gnt_q;
      hdr_d      = hdr_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      sop_d      = sop_q;
      data_d     = data_q;
      first_d    = first_q;
      hdr_rdreq  = '0;
      rd_done    = '0;
      dout_valid = 1'b0;
      dout_data  = '0;
      dout_sop   = 1'b0;
      dout_eop   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (en && w_any) begin
               ptr_d   = w_grant;
               gnt_d   = w_grant;
               state_d = S_POP;
            end
         end
         S_POP: begin
            hdr_rdreq[gnt_q] = 1'b1;
            hdr_d            = w_hdr_sel;
            addr_d           = w_start;
            // beats still to send after the first; modular so a full ring is 2^W-1
            rem_d            = w_stop - w_start;
            sop_d            = 1'b1;
            state_d          = S_RADDR;
         end
         S_RADDR: begin
            first_d = 1'b1;
            state_d = S_DATA;
         end
         S_DATA: begin
            // first cycle forwards the RAM output and captures it for any stall
            dout_valid = 1'b1;
            dout_data  = first_q ? w_rd_sel : data_q;
            dout_sop   = sop_q;
            dout_eop   = (rem_q == '0);
            if (first_q) begin
               data_d  = w_rd_sel;
               first_d = 1'b0;
            end
            if (dout_ready) begin
               if (rem_q != '0) begin
                  addr_d  = addr_q + 1'b1;
                  rem_d   = rem_q - 1'b1;
                  sop_d   = 1'b0;
                  state_d = S_RADDR;
               end else begin
                  rd_done[gnt_q] = 1'b1;
                  state_d        = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign wvb_rd_addr = addr_q;
   assign dout_hdr    = hdr_q;
   assign dout_chan   = gnt_q;
   assign busy        = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_wvb_rd_sched.sv
// tb_wvb_rd_sched: directed + randomized checks of wvb_rd_sched against an event-level queue model.
`default_nettype none
`timescale 1ns/1ps

module tb_wvb_rd_sched;

   localparam int N     = 4;
   localparam int DW    = 22;
   localparam int AW    = 12;
   localparam int HW    = 160;
   localparam int CW    = 2;
   localparam int DEPTH = 1 << AW;

   logic            clk = 1'b0;
   logic            rst;
   logic            en;
   logic [N-1:0]    hdr_empty;
   logic [N*HW-1:0] hdr_data;
   logic [N-1:0]    hdr_rdreq;
   logic [AW-1:0]   wvb_rd_addr;
   logic [N*DW-1:0] wvb_rd_data;
   logic            dout_valid;
   logic            dout_ready;
   logic [DW-1:0]   dout_data;
   logic            dout_sop;
   logic            dout_eop;
   logic [HW-1:0]   dout_hdr;
   logic [CW-1:0]   dout_chan;
   logic [N-1:0]    rd_done;
   logic            busy;

   wvb_rd_sched #(
      .P_N_CHAN     (N),
      .P_DATA_WIDTH (DW),
      .P_ADR_WIDTH  (AW),
      .P_HDR_WIDTH  (HW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .hdr_empty   (hdr_empty),
      .hdr_data    (hdr_data),
      .hdr_rdreq   (hdr_rdreq),
      .wvb_rd_addr (wvb_rd_addr),
      .wvb_rd_data (wvb_rd_data),
      .dout_valid  (dout_valid),
      .dout_ready  (dout_ready),
      .dout_data   (dout_data),
      .dout_sop    (dout_sop),
      .dout_eop    (dout_eop),
      .dout_hdr    (dout_hdr),
      .dout_chan   (dout_chan),
      .rd_done     (rd_done),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // per-channel registered RAMs, one cycle read latency
   logic [DW-1:0] mem   [N][DEPTH];
   logic [DW-1:0] ram_q [N];

   always @(posedge clk) begin
      for (int k = 0; k < N; k++) ram_q[k] <= mem[k][wvb_rd_addr];
   end

   always_comb begin
      wvb_rd_data = '0;
      for (int k = 0; k < N; k++) wvb_rd_data[k*DW +: DW] = ram_q[k];
   end

   logic [HW-1:0] hq [N][$];
   int            mptr;
   int            pend = -1;
   int            n_cmp = 0;
   int            n_fail = 0;

   task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_hdr();
      for (int k = 0; k < N; k++) begin
         hdr_empty[k]         = (hq[k].size() == 0);
         hdr_data[k*HW +: HW] = (hq[k].size() == 0) ? '0 : hq[k][0];
      end
   endtask

   // one clock: apply the pop requested last cycle, refresh FWFT heads, sample
   task automatic step();
      @(negedge clk);
      if (pend >= 0) begin
         if (hq[pend].size() > 0) void'(hq[pend].pop_front());
         pend = -1;
      end
      drive_hdr();
      #1;
      for (int k = N - 1; k >= 0; k--) if (hdr_rdreq[k]) pend = k;
   endtask

   task automatic push(input int ch, input logic [AW-1:0] start, input logic [AW-1:0] stop);
      logic [HW-1:0] h;
      h = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      h[AW-1:0]    = stop;
      h[2*AW-1:AW] = start;
      hq[ch].push_back(h);
   endtask

   function automatic int predict();
      int c;
      for (int i = 1; i <= N; i++) begin
         c = (mptr + i) % N;
         if (hq[c].size() > 0) begin
            mptr = c;
            return c;
         end
      end
      return -1;
   endfunction

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, dout_valid, 0);
      chk({tag, "_rdreq"}, hdr_rdreq, 0);
      chk({tag, "_addr"},  wvb_rd_addr, 0);
      chk({tag, "_data"},  dout_data, 0);
      chk({tag, "_sop"},   dout_sop, 0);
      chk({tag, "_eop"},   dout_eop, 0);
      chk({tag, "_hdr"},   dout_hdr, 0);
      chk({tag, "_chan"},  dout_chan, 0);
      chk({tag, "_done"},  rd_done, 0);
      chk({tag, "_busy"},  busy, 0);
   endtask

   // Serve one event: expected channel from the model, beats from the header span
   task automatic collect_event(input int bp_beat, input int bp_len, input bit drop_en);
      int            ch, n, guard;
      logic [AW-1:0] a, st, sp, span;
      logic [HW-1:0] h;
      logic [DW-1:0] d;
      logic [N-1:0]  oh;
      ch = predict();
      if (ch < 0) begin
         chk("model_pending", hdr_empty, {N{1'b0}});
         return;
      end
      h  = hq[ch][0];
      oh = '0;
      oh[ch] = 1'b1;
      guard = 0;
      do begin step(); guard++; end while (hdr_rdreq == '0 && guard < 20);
      chk("hdr_rdreq", hdr_rdreq, oh);
      if (hdr_rdreq == '0) return;
      if (drop_en) en = 1'b0;
      st   = h[2*AW-1:AW];
      sp   = h[AW-1:0];
      span = sp - st;
      n    = int'(span) + 1;
      a    = st;
      for (int b = 0; b < n; b++) begin
         guard = 0;
         do begin step(); guard++; end while (!dout_valid && guard < 8);
         if (!dout_valid) begin
            chk("beat_valid", dout_valid, 1);
            return;
         end
         d = mem[ch][a];
         if (b == bp_beat) begin
            dout_ready = 1'b0;
            for (int j = 1; j <= bp_len; j++) begin
               step();
               chk("stall_valid", dout_valid, 1);
               chk("stall_data",  dout_data, d);
               chk("stall_sop",   dout_sop, (b == 0));
               chk("stall_eop",   dout_eop, (b == n - 1));
               chk("stall_hdr",   dout_hdr, h);
               chk("stall_addr",  wvb_rd_addr, a);
               chk("stall_done",  rd_done, 0);
            end
            dout_ready = 1'b1;
         end
         #1;
         chk("beat_data", dout_data, d);
         chk("beat_sop",  dout_sop, (b == 0));
         chk("beat_eop",  dout_eop, (b == n - 1));
         chk("beat_hdr",  dout_hdr, h);
         chk("beat_chan", dout_chan, ch);
         chk("beat_addr", wvb_rd_addr, a);
         chk("beat_done", rd_done, (b == n - 1) ? oh : '0);
         chk("beat_busy", busy, 1);
         a = a + 1'b1;
      end
      step();
      chk("gap_busy",  busy, 0);
      chk("gap_valid", dout_valid, 0);
      chk("gap_done",  rd_done, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      logic [AW-1:0] s;
      for (int k = 0; k < N; k++)
         for (int i = 0; i < DEPTH; i++) mem[k][i] = DW'($urandom());
      rst        = 1'b1;
      en         = 1'b0;
      dout_ready = 1'b1;
      hdr_empty  = '1;
      hdr_data   = '0;
      mptr       = N - 1;
      repeat (3) step();
      check_zero("reset");
      rst = 1'b0;
      en  = 1'b1;
      step();
      check_zero("post_reset");

      // basic ch0 event, then a wrapping event on ch3 (leaves ptr at 3)
      push(0, 12'd10, 12'd13);
      collect_event(-1, 0, 1'b0);
      push(3, 12'd4094, 12'd1);
      collect_event(-1, 0, 1'b0);

      // all four pending: expect 0,1,2,3; then ch1 before ch3
      for (int k = 0; k < N; k++) begin
         s = AW'($urandom());
         push(k, s, s + AW'($urandom_range(0, 5)));
      end
      repeat (N) collect_event(-1, 0, 1'b0);
      push(3, 12'd50, 12'd52);
      push(1, 12'd60, 12'd61);
      collect_event(-1, 0, 1'b0);
      collect_event(-1, 0, 1'b0);

      // backpressure on beat 2 for 5 cycles, then a single-sample event
      push(2, 12'd300, 12'd305);
      collect_event(1, 5, 1'b0);
      push(1, 12'd7, 12'd7);
      collect_event(-1, 0, 1'b0);

      // repeated header on one channel interleaves with others
      push(0, 12'd20, 12'd22);
      push(0, 12'd30, 12'd31);
      push(1, 12'd40, 12'd40);
      repeat (3) collect_event(0, 1, 1'b0);

      // en dropped mid-event: event completes, pending header not granted
      push(3, 12'd500, 12'd503);
      push(0, 12'd510, 12'd511);
      collect_event(2, 2, 1'b1);
      repeat (6) begin
         step();
         chk("en_low_rdreq", hdr_rdreq, 0);
         chk("en_low_busy",  busy, 0);
      end
      en = 1'b1;
      collect_event(-1, 0, 1'b0);

      // full ring: 2^AW samples
      push(2, 12'd100, 12'd99);
      collect_event(-1, 0, 1'b0);

      // randomized traffic
      for (int it = 0; it < 12; it++) begin
         for (int p = 0; p < int'($urandom_range(1, 3)); p++) begin
            s = AW'($urandom());
            push(int'($urandom_range(0, N - 1)), s, s + AW'($urandom_range(0, 9)));
         end
         while (hq[0].size() + hq[1].size() + hq[2].size() + hq[3].size() > 0)
            collect_event(int'($urandom_range(0, 4)), int'($urandom_range(1, 3)), 1'b0);
      end

      // reset in the middle of an event
      push(1, 12'd200, 12'd207);
      void'(predict());
      guard = 0;
      do begin step(); guard++; end while (hdr_rdreq == '0 && guard < 20);
      chk("rstmid_rdreq", hdr_rdreq, 4'b0010);
      guard = 0;
      do begin step(); guard++; end while (!dout_valid && guard < 8);
      step();
      guard = 0;
      do begin step(); guard++; end while (!dout_valid && guard < 8);
      chk("rstmid_valid", dout_valid, 1);
      rst = 1'b1;
      step();
      check_zero("rst_mid");
      rst  = 1'b0;
      mptr = N - 1;
      en   = 1'b0;
      push(2, 12'd70, 12'd72);
      push(0, 12'd80, 12'd81);
      repeat (6) begin
         step();
         chk("en0_rdreq", hdr_rdreq, 0);
      end
      en = 1'b1;
      collect_event(-1, 0, 1'b0);
      collect_event(-1, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
